// File: rtl/multicycle_controller.sv
// Control FSM for the shared multicycle MIPS datapath: one set of enables/selects per state.
// Optional macro LOGIC_IMM_EN adds andi/ori (zero-extended immediate, logic ALU op).
module multicycle_controller #(
  parameter int unsigned STATE_W     = 4,
  parameter int unsigned RESET_STATE = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               ext_sel,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = STATE_W'(0),
    S_DECODE = STATE_W'(1),
    S_MEMADR = STATE_W'(2),
    S_MEMRD  = STATE_W'(3),
    S_MEMWB  = STATE_W'(4),
    S_MEMWR  = STATE_W'(5),
    S_EXEC   = STATE_W'(6),
    S_ALUWB  = STATE_W'(7),
    S_BRANCH = STATE_W'(8),
    S_JUMP   = STATE_W'(9),
    S_IMMEX  = STATE_W'(10),
    S_IMMWB  = STATE_W'(11),
    S_HALT   = STATE_W'(12)
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
`ifdef LOGIC_IMM_EN
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
`endif

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_op_q;
  logic       r_illegal;

  // State, latched opcode and sticky illegal flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= state_t'(STATE_W'(RESET_STATE));
      r_op_q    <= 6'd0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op_q <= opcode;
      if (w_next == S_HALT) r_illegal <= 1'b1;
    end
  end

  // Next state and per-state datapath controls; reset low masks every control
  always_comb begin
    w_next        = r_state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = 2'd0;
    pc_source     = 2'd0;
    ext_sel       = 1'b0;

    unique case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        unique case (opcode)
          OP_R:         w_next = S_EXEC;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_IMMEX;
`ifdef LOGIC_IMM_EN
          OP_ANDI, OP_ORI: w_next = S_IMMEX;
`endif
          default:      w_next = S_HALT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        w_next    = (r_op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd2;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        w_next    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'd1;
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
        w_next        = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'd2;
        w_next    = S_FETCH;
      end
      S_IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
`ifdef LOGIC_IMM_EN
        if (r_op_q == OP_ANDI || r_op_q == OP_ORI) begin
          ext_sel = 1'b1;
          alu_op  = 2'd3;
        end
`endif
        w_next = S_IMMWB;
      end
      S_IMMWB: begin
        reg_write = 1'b1;
        w_next    = S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_HALT;
    endcase

    if (!rst_n) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'd0;
      alu_op        = 2'd0;
      pc_source     = 2'd0;
      ext_sel       = 1'b0;
    end
  end

  assign illegal_op = r_illegal;
  assign state_dbg  = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed per-cycle stimulus queues expected
// state/controls; a negedge monitor pops and compares.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_write, reg_dst, alu_src_a, ext_sel, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_dbg;

  multicycle_controller #(.STATE_W(4), .RESET_STATE(0)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .reg_dst(reg_dst),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .ext_sel(ext_sel), .illegal_op(illegal_op),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI = 6'b001101, OP_BAD = 6'b111111;

  typedef struct {
    int          idx;
    logic [3:0]  st;
    logic [16:0] ctl;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc_idx  = 0;

  // Expected controls for a state, straight from the per-state control table.
  // Packing: {pc_write,pc_write_cond,iord,mem_read,mem_write,ir_write,mem_to_reg,
  //           reg_write,reg_dst,alu_src_a,alu_src_b[1:0],alu_op[1:0],pc_source[1:0],ext_sel}
  function automatic logic [16:0] ref_ctl(input logic [3:0] st, input logic mr,
                                          input logic rn, input logic [5:0] opq);
    logic pw, pwc, io, mrd, mwr, irw, m2r, rw, rd, sa, es;
    logic [1:0] sb, ao, ps;
    {pw, pwc, io, mrd, mwr, irw, m2r, rw, rd, sa, es} = '0;
    sb = 2'd0; ao = 2'd0; ps = 2'd0;
    case (st)
      4'd0:  begin mrd = 1; sb = 2'd1; irw = mr; pw = mr; end
      4'd1:  sb = 2'd3;
      4'd2:  begin sa = 1; sb = 2'd2; end
      4'd3:  begin mrd = 1; io = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin io = 1; mwr = 1; end
      4'd6:  begin sa = 1; ao = 2'd2; end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin sa = 1; ao = 2'd1; pwc = 1; ps = 2'd1; end
      4'd9:  begin pw = 1; ps = 2'd2; end
      4'd10: begin
        sa = 1; sb = 2'd2;
`ifdef LOGIC_IMM_EN
        if (opq == 6'b001100 || opq == 6'b001101) begin es = 1; ao = 2'd3; end
`else
        if (opq == 6'b111110) es = 1'b0;
`endif
      end
      4'd11: rw = 1;
      default: ;
    endcase
    if (!rn) return 17'd0;
    return {pw, pwc, io, mrd, mwr, irw, m2r, rw, rd, sa, sb, ao, ps, es};
  endfunction

  // Drive one cycle of inputs and queue what the DUT must show during it
  task automatic cyc(input logic rn, input logic [5:0] op, input logic mr,
                     input logic [3:0] est, input logic eill, input logic [5:0] eopq);
    exp_t e;
    rst_n = rn; opcode = op; mem_ready = mr;
    e.idx = cyc_idx; e.st = est; e.ill = eill;
    e.ctl = ref_ctl(est, mr, rn, eopq);
    q.push_back(e);
    cyc_idx++;
    @(posedge clk); #1;
  endtask

  // Monitor: compare current outputs against the oldest queued expectation
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [16:0] act;
      e = q.pop_front();
      act = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
             reg_write, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source, ext_sel};
      n_checks++;
      if (state_dbg === e.st) n_pass++;
      else $display("FAIL state cyc%0d: got %0d expected %0d", e.idx, state_dbg, e.st);
      n_checks++;
      if (act === e.ctl) n_pass++;
      else $display("FAIL ctl cyc%0d st%0d: got %b expected %b", e.idx, e.st, act, e.ctl);
      n_checks++;
      if (illegal_op === e.ill) n_pass++;
      else $display("FAIL illegal_op cyc%0d: got %b expected %b", e.idx, illegal_op, e.ill);
    end
  end

  initial begin
    rst_n = 1'b0; opcode = OP_R; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // reset held: FETCH with every control masked even though mem_ready=1
    cyc(0, OP_R, 1, 4'd0, 0, OP_R);
    // R-type: 0,1,6,7
    cyc(1, OP_R, 1, 4'd0, 0, OP_R);
    cyc(1, OP_R, 1, 4'd1, 0, OP_R);
    cyc(1, OP_LW, 1, 4'd6, 0, OP_R);
    cyc(1, OP_SW, 1, 4'd7, 0, OP_R);
    // lw with two MEMRD stalls; opcode changes after DECODE are ignored
    cyc(1, OP_LW, 1, 4'd0, 0, OP_LW);
    cyc(1, OP_LW, 1, 4'd1, 0, OP_LW);
    cyc(1, OP_SW, 1, 4'd2, 0, OP_LW);
    cyc(1, OP_SW, 0, 4'd3, 0, OP_LW);
    cyc(1, OP_R, 0, 4'd3, 0, OP_LW);
    cyc(1, OP_R, 1, 4'd3, 0, OP_LW);
    cyc(1, OP_J, 0, 4'd4, 0, OP_LW);
    // sw with one FETCH stall
    cyc(1, OP_SW, 0, 4'd0, 0, OP_SW);
    cyc(1, OP_SW, 1, 4'd0, 0, OP_SW);
    cyc(1, OP_SW, 1, 4'd1, 0, OP_SW);
    cyc(1, OP_LW, 1, 4'd2, 0, OP_SW);
    cyc(1, OP_LW, 1, 4'd5, 0, OP_SW);
    // beq then j; mem_ready low outside memory states has no effect
    cyc(1, OP_BEQ, 1, 4'd0, 0, OP_BEQ);
    cyc(1, OP_BEQ, 0, 4'd1, 0, OP_BEQ);
    cyc(1, OP_R, 0, 4'd8, 0, OP_BEQ);
    cyc(1, OP_J, 1, 4'd0, 0, OP_J);
    cyc(1, OP_J, 1, 4'd1, 0, OP_J);
    cyc(1, OP_BAD, 0, 4'd9, 0, OP_J);
    // addi
    cyc(1, OP_ADDI, 1, 4'd0, 0, OP_ADDI);
    cyc(1, OP_ADDI, 1, 4'd1, 0, OP_ADDI);
    cyc(1, OP_BAD, 1, 4'd10, 0, OP_ADDI);
    cyc(1, OP_BAD, 1, 4'd11, 0, OP_ADDI);
    // ori: logic-immediate path when enabled, otherwise halts
    cyc(1, OP_ORI, 1, 4'd0, 0, OP_ORI);
    cyc(1, OP_ORI, 1, 4'd1, 0, OP_ORI);
`ifdef LOGIC_IMM_EN
    cyc(1, OP_R, 1, 4'd10, 0, OP_ORI);
    cyc(1, OP_R, 1, 4'd11, 0, OP_ORI);
`else
    cyc(1, OP_R, 1, 4'd12, 1, OP_ORI);
    cyc(1, OP_R, 1, 4'd12, 1, OP_ORI);
    cyc(0, OP_R, 1, 4'd12, 1, OP_ORI);
`endif
    // illegal opcode: HALT held 10 cycles regardless of inputs, then reset
    cyc(1, OP_BAD, 1, 4'd0, 0, OP_BAD);
    cyc(1, OP_BAD, 1, 4'd1, 0, OP_BAD);
    for (int i = 0; i < 10; i++)
      cyc(1, 6'(i), 1'(i % 2), 4'd12, 1, OP_BAD);
    cyc(0, OP_R, 1, 4'd12, 1, OP_BAD);
    cyc(1, OP_R, 0, 4'd0, 0, OP_R);
    // reset during MEMWR drops mem_write that cycle, then FETCH
    cyc(1, OP_SW, 1, 4'd0, 0, OP_SW);
    cyc(1, OP_SW, 1, 4'd1, 0, OP_SW);
    cyc(1, OP_SW, 1, 4'd2, 0, OP_SW);
    cyc(1, OP_SW, 0, 4'd5, 0, OP_SW);
    cyc(0, OP_SW, 0, 4'd5, 0, OP_SW);
    cyc(1, OP_R, 1, 4'd0, 0, OP_R);
    cyc(1, OP_R, 1, 4'd1, 0, OP_R);
    cyc(1, OP_R, 1, 4'd6, 0, OP_R);
    @(negedge clk); #1;
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
